// File: rtl/riscv_ctrl_pkg.sv
// RV32I decode constants (opcodes, ALU codes, operand selects, access sizes) and the decoded bundle.
package riscv_ctrl_pkg;

    localparam int unsigned ALU_W = 6;
    localparam int unsigned REG_W = 5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [ALU_W-1:0] ALU_DEFAULT = 6'd0;
    localparam logic [ALU_W-1:0] ALU_ADD     = 6'd1;
    localparam logic [ALU_W-1:0] ALU_SUB     = 6'd2;
    localparam logic [ALU_W-1:0] ALU_SLL     = 6'd3;
    localparam logic [ALU_W-1:0] ALU_SLT     = 6'd4;
    localparam logic [ALU_W-1:0] ALU_SLTU    = 6'd5;
    localparam logic [ALU_W-1:0] ALU_XOR     = 6'd6;
    localparam logic [ALU_W-1:0] ALU_SRL     = 6'd7;
    localparam logic [ALU_W-1:0] ALU_SRA     = 6'd8;
    localparam logic [ALU_W-1:0] ALU_OR      = 6'd9;
    localparam logic [ALU_W-1:0] ALU_AND     = 6'd10;
    localparam logic [ALU_W-1:0] ALU_STORE   = 6'd11;
    localparam logic [ALU_W-1:0] ALU_BEQ     = 6'd12;
    localparam logic [ALU_W-1:0] ALU_BNE     = 6'd13;
    localparam logic [ALU_W-1:0] ALU_BLT     = 6'd14;
    localparam logic [ALU_W-1:0] ALU_BGE     = 6'd15;
    localparam logic [ALU_W-1:0] ALU_BLTU    = 6'd16;
    localparam logic [ALU_W-1:0] ALU_BGEU    = 6'd17;
    localparam logic [ALU_W-1:0] ALU_JAL     = 6'd18;
    localparam logic [ALU_W-1:0] ALU_JALR    = 6'd19;
    localparam logic [ALU_W-1:0] ALU_MUL     = 6'd20;
    localparam logic [ALU_W-1:0] ALU_MULH    = 6'd21;
    localparam logic [ALU_W-1:0] ALU_MULHSU  = 6'd22;
    localparam logic [ALU_W-1:0] ALU_MULHU   = 6'd23;
    localparam logic [ALU_W-1:0] ALU_DIV     = 6'd24;
    localparam logic [ALU_W-1:0] ALU_DIVU    = 6'd25;
    localparam logic [ALU_W-1:0] ALU_REM     = 6'd26;
    localparam logic [ALU_W-1:0] ALU_REMU    = 6'd27;

    localparam logic [1:0] OPA_RS1  = 2'b00;
    localparam logic [1:0] OPA_PC   = 2'b01;
    localparam logic [1:0] OPA_PC4  = 2'b10;
    localparam logic [1:0] OPA_ZERO = 2'b11;

    localparam logic [1:0] SIZE_BYTE  = 2'd0;
    localparam logic [1:0] SIZE_HWORD = 2'd1;
    localparam logic [1:0] SIZE_WORD  = 2'd2;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             wb_en;
        logic             mem_wen;
        logic [1:0]       op_a_sel;
        logic             op_b_sel;
        logic [ALU_W-1:0] alu_ctrl;
        logic             branch_op;
        logic [1:0]       mem_size;
        logic             load_sign;
        logic             wb_sel;
        logic             illegal;
    } decoded_t;

    // Idle bundle: everything off, ALU at its default code, word-sized access.
    function automatic decoded_t reset_bundle();
        decoded_t b;
        b          = '0;
        b.alu_ctrl = ALU_DEFAULT;
        b.mem_size = SIZE_WORD;
        return b;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I decoder: instruction word -> control bundle; illegal encodings yield an idle bundle.
// Optional M-extension decode is enabled by defining DECODE_RV32M_EN.
module instr_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output decoded_t    dec_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    decoded_t   dec_c;
    logic       bad_c;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        dec_c = reset_bundle();
        bad_c = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                dec_c.wb_en = 1'b1;
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'd0: dec_c.alu_ctrl = ALU_ADD;
                            3'd1: dec_c.alu_ctrl = ALU_SLL;
                            3'd2: dec_c.alu_ctrl = ALU_SLT;
                            3'd3: dec_c.alu_ctrl = ALU_SLTU;
                            3'd4: dec_c.alu_ctrl = ALU_XOR;
                            3'd5: dec_c.alu_ctrl = ALU_SRL;
                            3'd6: dec_c.alu_ctrl = ALU_OR;
                            3'd7: dec_c.alu_ctrl = ALU_AND;
                        endcase
                    end
                    7'b0100000: begin
                        case (funct3)
                            3'd0:    dec_c.alu_ctrl = ALU_SUB;
                            3'd5:    dec_c.alu_ctrl = ALU_SRA;
                            default: bad_c = 1'b1;
                        endcase
                    end
`ifdef DECODE_RV32M_EN
                    7'b0000001: begin
                        case (funct3)
                            3'd0: dec_c.alu_ctrl = ALU_MUL;
                            3'd1: dec_c.alu_ctrl = ALU_MULH;
                            3'd2: dec_c.alu_ctrl = ALU_MULHSU;
                            3'd3: dec_c.alu_ctrl = ALU_MULHU;
                            3'd4: dec_c.alu_ctrl = ALU_DIV;
                            3'd5: dec_c.alu_ctrl = ALU_DIVU;
                            3'd6: dec_c.alu_ctrl = ALU_REM;
                            3'd7: dec_c.alu_ctrl = ALU_REMU;
                        endcase
                    end
`endif
                    default: bad_c = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                dec_c.wb_en    = 1'b1;
                dec_c.op_b_sel = 1'b1;
                case (funct3)
                    3'd0: dec_c.alu_ctrl = ALU_ADD;
                    3'd2: dec_c.alu_ctrl = ALU_SLT;
                    3'd3: dec_c.alu_ctrl = ALU_SLTU;
                    3'd4: dec_c.alu_ctrl = ALU_XOR;
                    3'd6: dec_c.alu_ctrl = ALU_OR;
                    3'd7: dec_c.alu_ctrl = ALU_AND;
                    3'd1: begin
                        dec_c.alu_ctrl = ALU_SLL;
                        bad_c          = (funct7 != 7'b0000000);
                    end
                    3'd5: begin
                        // instr[30] picks arithmetic shift; every other funct7 bit must be clear
                        dec_c.alu_ctrl = instr_i[30] ? ALU_SRA : ALU_SRL;
                        bad_c          = ({funct7[6], funct7[4:0]} != 6'b0);
                    end
                endcase
            end
            OPC_LOAD: begin
                dec_c.wb_en    = 1'b1;
                dec_c.wb_sel   = 1'b1;
                dec_c.op_b_sel = 1'b1;
                dec_c.alu_ctrl = ALU_ADD;
                case (funct3)
                    3'd0:    begin dec_c.mem_size = SIZE_BYTE;  dec_c.load_sign = 1'b1; end
                    3'd1:    begin dec_c.mem_size = SIZE_HWORD; dec_c.load_sign = 1'b1; end
                    3'd2:    begin dec_c.mem_size = SIZE_WORD;  dec_c.load_sign = 1'b1; end
                    3'd4:    dec_c.mem_size = SIZE_BYTE;
                    3'd5:    dec_c.mem_size = SIZE_HWORD;
                    default: bad_c = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec_c.mem_wen  = 1'b1;
                dec_c.op_b_sel = 1'b1;
                dec_c.alu_ctrl = ALU_STORE;
                case (funct3)
                    3'd0:    dec_c.mem_size = SIZE_BYTE;
                    3'd1:    dec_c.mem_size = SIZE_HWORD;
                    3'd2:    dec_c.mem_size = SIZE_WORD;
                    default: bad_c = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                dec_c.branch_op = 1'b1;
                case (funct3)
                    3'd0:    dec_c.alu_ctrl = ALU_BEQ;
                    3'd1:    dec_c.alu_ctrl = ALU_BNE;
                    3'd4:    dec_c.alu_ctrl = ALU_BLT;
                    3'd5:    dec_c.alu_ctrl = ALU_BGE;
                    3'd6:    dec_c.alu_ctrl = ALU_BLTU;
                    3'd7:    dec_c.alu_ctrl = ALU_BGEU;
                    default: bad_c = 1'b1;
                endcase
            end
            OPC_JAL: begin
                dec_c.wb_en    = 1'b1;
                dec_c.op_a_sel = OPA_PC4;
                dec_c.alu_ctrl = ALU_JAL;
            end
            OPC_JALR: begin
                dec_c.wb_en    = 1'b1;
                dec_c.op_a_sel = OPA_PC4;
                dec_c.alu_ctrl = ALU_JALR;
            end
            OPC_AUIPC: begin
                dec_c.wb_en    = 1'b1;
                dec_c.op_a_sel = OPA_PC;
                dec_c.op_b_sel = 1'b1;
                dec_c.alu_ctrl = ALU_ADD;
            end
            OPC_LUI: begin
                dec_c.wb_en    = 1'b1;
                dec_c.op_a_sel = OPA_ZERO;
                dec_c.op_b_sel = 1'b1;
                dec_c.alu_ctrl = ALU_ADD;
            end
            default: bad_c = 1'b1;
        endcase

        if (bad_c) begin
            dec_c         = reset_bundle();
            dec_c.illegal = 1'b1;
        end
        dec_c.rd  = instr_i[11:7];
        dec_c.rs1 = instr_i[19:15];
        dec_c.rs2 = instr_i[24:20];
    end

    assign dec_o = dec_c;

endmodule

// File: rtl/decode_stage.sv
// Flow-controlled decode stage: DEPTH-entry instruction FIFO feeding a registered decoded bundle.
// M-extension decode is selected in instr_decoder by defining DECODE_RV32M_EN.
module decode_stage
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PC_W  = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [PC_W-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_W-1:0]      out_pc,
    output logic [REG_W-1:0]     out_rd,
    output logic [REG_W-1:0]     out_rs1,
    output logic [REG_W-1:0]     out_rs2,
    output logic                 wb_en,
    output logic                 mem_wen,
    output logic [1:0]           op_a_sel,
    output logic                 op_b_sel,
    output logic [ALU_W-1:0]     alu_ctrl,
    output logic                 branch_op,
    output logic [1:0]           mem_size,
    output logic                 load_sign,
    output logic                 wb_sel,
    output logic                 illegal
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      instr_mem_q [DEPTH];
    logic [PC_W-1:0]  pc_mem_q    [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [PC_W-1:0]  out_pc_q, out_pc_d;
    decoded_t         out_q, out_d;
    decoded_t         head_dec;
    logic             full, empty, push, pop;

    instr_decoder u_dec (
        .instr_i (instr_mem_q[rd_ptr_q]),
        .dec_o   (head_dec)
    );

    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign in_ready = !full && !reset;
    assign push     = in_valid && in_ready && !flush;
    assign pop      = !empty && (!out_valid_q || out_ready) && !flush;

    // Next state: flush wins over push and pop; a consumed bundle with nothing behind it goes invalid.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_d       = out_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d    = rd_ptr_q + PTR_W'(1);
                out_valid_d = 1'b1;
                out_pc_d    = pc_mem_q[rd_ptr_q];
                out_d       = head_dec;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_q       <= reset_bundle();
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_q       <= out_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the counter.
    always_ff @(posedge clock) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= in_instr;
            pc_mem_q[wr_ptr_q]    <= in_pc;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_rd    = out_q.rd;
    assign out_rs1   = out_q.rs1;
    assign out_rs2   = out_q.rs2;
    assign wb_en     = out_q.wb_en;
    assign mem_wen   = out_q.mem_wen;
    assign op_a_sel  = out_q.op_a_sel;
    assign op_b_sel  = out_q.op_b_sel;
    assign alu_ctrl  = out_q.alu_ctrl;
    assign branch_op = out_q.branch_op;
    assign mem_size  = out_q.mem_size;
    assign load_sign = out_q.load_sign;
    assign wb_sel    = out_q.wb_sel;
    assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed decode/stall/flush/reset steps, then randomized traffic vs a queue model.
module tb_decode_stage;
    import riscv_ctrl_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned PC_W  = 32;

    logic              clock, reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]       in_instr;
    logic [PC_W-1:0]   in_pc, out_pc;
    logic [4:0]        out_rd, out_rs1, out_rs2;
    logic              wb_en, mem_wen, op_b_sel, branch_op, load_sign, wb_sel, illegal;
    logic [1:0]        op_a_sel, mem_size;
    logic [5:0]        alu_ctrl;

    decode_stage #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .wb_en(wb_en), .mem_wen(mem_wen), .op_a_sel(op_a_sel), .op_b_sel(op_b_sel),
        .alu_ctrl(alu_ctrl), .branch_op(branch_op), .mem_size(mem_size),
        .load_sign(load_sign), .wb_sel(wb_sel), .illegal(illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    decoded_t obs_b;
    always_comb begin
        obs_b           = '0;
        obs_b.rd        = out_rd;
        obs_b.rs1       = out_rs1;
        obs_b.rs2       = out_rs2;
        obs_b.wb_en     = wb_en;
        obs_b.mem_wen   = mem_wen;
        obs_b.op_a_sel  = op_a_sel;
        obs_b.op_b_sel  = op_b_sel;
        obs_b.alu_ctrl  = alu_ctrl;
        obs_b.branch_op = branch_op;
        obs_b.mem_size  = mem_size;
        obs_b.load_sign = load_sign;
        obs_b.wb_sel    = wb_sel;
        obs_b.illegal   = illegal;
    end

    typedef struct { logic [31:0] instr; logic [PC_W-1:0] pc; } item_t;
    item_t q[$];
    int tests  = 0;
    int failed = 0;

    localparam logic [5:0] R_BASE [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                          ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    localparam logic [5:0] R_MUL  [8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                                          ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    localparam logic [5:0] BR_TBL [8] = '{ALU_BEQ, ALU_BNE, ALU_DEFAULT, ALU_DEFAULT,
                                          ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
    localparam logic [6:0] OPCS   [9] = '{OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                                          OPC_JAL, OPC_JALR, OPC_AUIPC, OPC_LUI};
`ifdef DECODE_RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    function automatic decoded_t idle_bundle();
        decoded_t e;
        e          = '0;
        e.alu_ctrl = ALU_DEFAULT;
        e.mem_size = SIZE_WORD;
        return e;
    endfunction

    function automatic logic [1:0] size_of(input logic [1:0] f);
        return (f == 2'd0) ? SIZE_BYTE : (f == 2'd1) ? SIZE_HWORD : SIZE_WORD;
    endfunction

    // Reference decode built from the instruction-set tables.
    function automatic decoded_t exp_dec(input logic [31:0] w);
        decoded_t   e;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         ok;
        e  = idle_bundle();
        f3 = w[14:12];
        f7 = w[31:25];
        ok = 1'b1;
        case (w[6:0])
            OPC_OP: begin
                e.wb_en = 1'b1;
                if (f7 == 7'h00)                          e.alu_ctrl = R_BASE[f3];
                else if (f7 == 7'h20 && f3 == 3'd0)       e.alu_ctrl = ALU_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5)       e.alu_ctrl = ALU_SRA;
                else if (f7 == 7'h01 && M_EN)             e.alu_ctrl = R_MUL[f3];
                else                                      ok = 1'b0;
            end
            OPC_OP_IMM: begin
                e.wb_en    = 1'b1;
                e.op_b_sel = 1'b1;
                if (f3 == 3'd5 && f7 == 7'h20)            e.alu_ctrl = ALU_SRA;
                else if ((f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00) ok = 1'b0;
                else                                      e.alu_ctrl = R_BASE[f3];
            end
            OPC_LOAD: begin
                ok          = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
                e.wb_en     = 1'b1;
                e.wb_sel    = 1'b1;
                e.op_b_sel  = 1'b1;
                e.alu_ctrl  = ALU_ADD;
                e.mem_size  = size_of(f3[1:0]);
                e.load_sign = !f3[2];
            end
            OPC_STORE: begin
                ok         = (f3 <= 3'd2);
                e.mem_wen  = 1'b1;
                e.op_b_sel = 1'b1;
                e.alu_ctrl = ALU_STORE;
                e.mem_size = size_of(f3[1:0]);
            end
            OPC_BRANCH: begin
                ok          = !(f3 == 3'd2 || f3 == 3'd3);
                e.branch_op = 1'b1;
                e.alu_ctrl  = BR_TBL[f3];
            end
            OPC_JAL:   begin e.wb_en = 1'b1; e.op_a_sel = OPA_PC4;  e.alu_ctrl = ALU_JAL;  end
            OPC_JALR:  begin e.wb_en = 1'b1; e.op_a_sel = OPA_PC4;  e.alu_ctrl = ALU_JALR; end
            OPC_AUIPC: begin e.wb_en = 1'b1; e.op_a_sel = OPA_PC;   e.op_b_sel = 1'b1; e.alu_ctrl = ALU_ADD; end
            OPC_LUI:   begin e.wb_en = 1'b1; e.op_a_sel = OPA_ZERO; e.op_b_sel = 1'b1; e.alu_ctrl = ALU_ADD; end
            default:   ok = 1'b0;
        endcase
        if (!ok) begin
            e         = idle_bundle();
            e.illegal = 1'b1;
        end
        e.rd  = w[11:7];
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int          s;
        w = $urandom;
        s = int'($urandom_range(0, 10));
        if (s < 9) w[6:0] = OPCS[s];
        case ($urandom_range(0, 3))
            0:       w[31:25] = 7'h00;
            1:       w[31:25] = 7'h20;
            2:       w[31:25] = 7'h01;
            default: w[31:25] = w[31:25];
        endcase
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Push one instruction into an idle stage and capture its bundle two cycles later.
    task automatic run_one(input logic [31:0] w, input logic [31:0] pc,
                           output decoded_t got, output logic [31:0] got_pc);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = w;
        in_pc     = pc;
        tick();
        in_valid = 1'b0;
        check("lat_first_cycle", 64'(out_valid), 64'(0));
        tick();
        check("lat_second_cycle", 64'(out_valid), 64'(1));
        got    = obs_b;
        got_pc = out_pc;
        check("one_vs_model", 64'({out_pc, obs_b}), 64'({pc, exp_dec(w)}));
        tick();
    endtask

    initial begin
        decoded_t    got;
        decoded_t    rst_exp;
        logic [31:0] got_pc;
        int          accepted;
        int          seen;
        int          fifo_n;
        bit          ov_m;
        item_t       it;

        rst_exp   = idle_bundle();
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        tick(); tick(); tick();
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_bundle", 64'(obs_b), 64'(rst_exp));
        check("rst_out_pc", 64'(out_pc), 64'(0));
        reset = 1'b0;
        tick();
        check("post_rst_in_ready", 64'(in_ready), 64'(1));

        run_one(32'h002081B3, 32'h0000_1000, got, got_pc);
        check("add_alu", 64'(got.alu_ctrl), 64'(ALU_ADD));
        check("add_wb_en", 64'(got.wb_en), 64'(1));
        check("add_op_b", 64'(got.op_b_sel), 64'(0));
        check("add_rd", 64'(got.rd), 64'(3));
        check("add_illegal", 64'(got.illegal), 64'(0));
        check("add_pc", 64'(got_pc), 64'(32'h0000_1000));

        run_one(32'h00812283, 32'h0000_1004, got, got_pc);
        check("lw_wb_sel", 64'(got.wb_sel), 64'(1));
        check("lw_size", 64'(got.mem_size), 64'(SIZE_WORD));
        check("lw_sign", 64'(got.load_sign), 64'(1));
        check("lw_wb_en", 64'(got.wb_en), 64'(1));
        check("lw_mem_wen", 64'(got.mem_wen), 64'(0));

        run_one(32'h00512223, 32'h0000_1008, got, got_pc);
        check("sw_mem_wen", 64'(got.mem_wen), 64'(1));
        check("sw_wb_en", 64'(got.wb_en), 64'(0));
        check("sw_alu", 64'(got.alu_ctrl), 64'(ALU_STORE));

        run_one(32'hFFFFFFFF, 32'h0000_100C, got, got_pc);
        check("ones_illegal", 64'(got.illegal), 64'(1));
        check("ones_enables", 64'({got.wb_en, got.mem_wen, got.branch_op}), 64'(0));

        run_one(32'h022081B3, 32'h0000_1010, got, got_pc);
`ifdef DECODE_RV32M_EN
        check("mul_alu", 64'(got.alu_ctrl), 64'(ALU_MUL));
        check("mul_illegal", 64'(got.illegal), 64'(0));
`else
        check("mul_illegal", 64'(got.illegal), 64'(1));
        check("mul_wb_en", 64'(got.wb_en), 64'(0));
`endif

        // Reset while a bundle is waiting: controls return to idle, queued work is lost.
        out_ready = 1'b0;
        in_valid  = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h40;
        tick();
        in_instr = 32'h00512223; in_pc = 32'h44;
        tick();
        in_valid = 1'b0;
        check("midrst_pre_valid", 64'(out_valid), 64'(1));
        reset = 1'b1;
        tick();
        check("midrst_valid", 64'(out_valid), 64'(0));
        check("midrst_bundle", 64'(obs_b), 64'(rst_exp));
        check("midrst_pc", 64'(out_pc), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(0));
        reset = 1'b0;
        tick(); tick();
        check("midrst_after_valid", 64'(out_valid), 64'(0));
        check("midrst_after_ready", 64'(in_ready), 64'(1));

        // Stall: four back-to-back offers with the consumer blocked.
        q.delete();
        accepted = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_instr = 32'h00000033 | (32'(k + 1) << 7);
            in_pc    = 32'h100 + 32'(4 * k);
            if (in_ready) begin
                accepted++;
                it.instr = in_instr;
                it.pc    = in_pc;
                q.push_back(it);
            end
            tick();
        end
        in_valid = 1'b0;
        check("stall_accepted", 64'(accepted), 64'(3));
        check("stall_in_ready", 64'(in_ready), 64'(0));
        tick(); tick();
        check("stall_hold", 64'({out_valid, out_pc, obs_b}),
              64'({1'b1, 32'h100, exp_dec(32'h000000B3)}));
        out_ready = 1'b1;
        seen      = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid && q.size() > 0) begin
                it = q.pop_front();
                check("stall_drain", 64'({out_pc, obs_b}), 64'({it.pc, exp_dec(it.instr)}));
                seen++;
            end
            tick();
        end
        check("stall_drain_count", 64'(seen), 64'(3));

        // Flush with two queued and a coinciding push.
        out_ready = 1'b0;
        in_valid  = 1'b1; in_instr = 32'h00100093; in_pc = 32'h200;
        tick();
        in_instr = 32'h00200113; in_pc = 32'h204;
        tick();
        flush = 1'b1; in_instr = 32'h00300193; in_pc = 32'h208;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", 64'(out_valid), 64'(0));
        check("flush_in_ready", 64'(in_ready), 64'(1));
        out_ready = 1'b1;
        seen      = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (out_valid) seen++;
        end
        check("flush_nothing_emerges", 64'(seen), 64'(0));

        // Random traffic against a queue model: q[0] is the output bundle while ov_m is set.
        q.delete();
        ov_m = 1'b0;
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = gen_instr();
            in_pc     = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            fifo_n    = q.size() - int'(ov_m);
            check("rnd_out_valid", 64'(out_valid), 64'(ov_m));
            check("rnd_in_ready", 64'(in_ready), 64'(fifo_n < int'(DEPTH)));
            if (ov_m && q.size() > 0) begin
                check("rnd_bundle", 64'({out_pc, obs_b}), 64'({q[0].pc, exp_dec(q[0].instr)}));
            end
            if (flush) begin
                q.delete();
                ov_m = 1'b0;
            end else begin
                if (ov_m && out_ready) void'(q.pop_front());
                ov_m = (ov_m && !out_ready) || (fifo_n > 0);
                if (in_valid && fifo_n < int'(DEPTH)) begin
                    it.instr = in_instr;
                    it.pc    = in_pc;
                    q.push_back(it);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
